// File: rtl/dmem_port_arbiter_if.sv
// rtl/dmem_port_arbiter_if.sv - bundle of core, DMA and memory-side signals for dmem_port_arbiter
//
// Purpose: groups the two requester ports, the shared memory port and the
// optional performance counters.
// Modports:
//   slave  - arbiter side: takes requests and mem_rdata, drives grants,
//            responses and the mem_* port
//   master - requester/memory side, the mirror of slave
// Optional: DMEM_ARB_PERF_EN adds perf_core_grants/perf_dma_grants/perf_conflicts.
interface dmem_port_arbiter_if;
  logic        core_req;
  logic        core_we;
  logic [3:0]  core_be;
  logic [31:0] core_addr;
  logic [31:0] core_wdata;
  logic        core_gnt;
  logic        core_rvalid;
  logic [31:0] core_rdata;

  logic        dma_req;
  logic        dma_we;
  logic [3:0]  dma_be;
  logic [31:0] dma_addr;
  logic [31:0] dma_wdata;
  logic        dma_gnt;
  logic        dma_rvalid;
  logic [31:0] dma_rdata;

  logic        mem_en;
  logic        mem_we;
  logic [3:0]  mem_be;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

`ifdef DMEM_ARB_PERF_EN
  logic [31:0] perf_core_grants;
  logic [31:0] perf_dma_grants;
  logic [31:0] perf_conflicts;

  modport slave (
    input  core_req, core_we, core_be, core_addr, core_wdata,
    input  dma_req, dma_we, dma_be, dma_addr, dma_wdata,
    input  mem_rdata,
    output core_gnt, core_rvalid, core_rdata,
    output dma_gnt, dma_rvalid, dma_rdata,
    output mem_en, mem_we, mem_be, mem_addr, mem_wdata,
    output perf_core_grants, perf_dma_grants, perf_conflicts
  );

  modport master (
    output core_req, core_we, core_be, core_addr, core_wdata,
    output dma_req, dma_we, dma_be, dma_addr, dma_wdata,
    output mem_rdata,
    input  core_gnt, core_rvalid, core_rdata,
    input  dma_gnt, dma_rvalid, dma_rdata,
    input  mem_en, mem_we, mem_be, mem_addr, mem_wdata,
    input  perf_core_grants, perf_dma_grants, perf_conflicts
  );
`else
  modport slave (
    input  core_req, core_we, core_be, core_addr, core_wdata,
    input  dma_req, dma_we, dma_be, dma_addr, dma_wdata,
    input  mem_rdata,
    output core_gnt, core_rvalid, core_rdata,
    output dma_gnt, dma_rvalid, dma_rdata,
    output mem_en, mem_we, mem_be, mem_addr, mem_wdata
  );

  modport master (
    output core_req, core_we, core_be, core_addr, core_wdata,
    output dma_req, dma_we, dma_be, dma_addr, dma_wdata,
    output mem_rdata,
    input  core_gnt, core_rvalid, core_rdata,
    input  dma_gnt, dma_rvalid, dma_rdata,
    input  mem_en, mem_we, mem_be, mem_addr, mem_wdata
  );
`endif
endinterface

// File: rtl/dmem_port_arbiter.sv
// rtl/dmem_port_arbiter.sv - two-requester data-memory port arbiter with starvation-bounded DMA priority
//
// Purpose: shares one data-memory port between the core MEM stage (requester 0)
// and a DMA/debug master (requester 1). The core wins by default; a DMA request
// denied for MAX_WAIT consecutive cycles gets up to DMA_BURST forced grants.
// Read data (1-cycle latency) is steered back to the requester that issued it.
// Ports:
//   clk   - clock
//   reset - asynchronous, active-high reset
//   bus   - dmem_port_arbiter_if.slave: core_*/dma_* request and response
//           fields, mem_* shared memory port
// Optional: DMEM_ARB_PERF_EN adds wrapping grant/conflict counters.
module dmem_port_arbiter #(
  parameter int MAX_WAIT  = 4,
  parameter int DMA_BURST = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  dmem_port_arbiter_if.slave    bus
);

  localparam logic [3:0] WAIT_MAX   = 4'(MAX_WAIT);
  localparam logic [3:0] WAIT_LAST  = 4'(MAX_WAIT - 1);
  localparam logic [3:0] BURST_LAST = 4'(DMA_BURST - 1);

  typedef enum logic {
    PRI_CORE = 1'b0,
    PRI_DMA  = 1'b1
  } state_e;

  state_e      state_q, state_d;
  logic [3:0]  wait_q, wait_d;
  logic [3:0]  burst_q, burst_d;
  logic        resp_valid_q, resp_valid_d;
  logic        resp_owner_q, resp_owner_d;  // 0 = core, 1 = DMA

  logic        core_gnt;
  logic        dma_gnt;
  logic        dma_denied;

  // Grant selection and memory port mux
  always_comb begin
    core_gnt = 1'b0;
    dma_gnt  = 1'b0;
    if (state_q == PRI_CORE) begin
      core_gnt = bus.core_req;
      dma_gnt  = bus.dma_req & ~bus.core_req;
    end else begin
      dma_gnt  = bus.dma_req;
      core_gnt = bus.core_req & ~bus.dma_req;
    end
  end

  always_comb begin
    bus.mem_en    = 1'b0;
    bus.mem_we    = 1'b0;
    bus.mem_be    = 4'b0;
    bus.mem_addr  = 32'b0;
    bus.mem_wdata = 32'b0;
    if (core_gnt) begin
      bus.mem_en    = 1'b1;
      bus.mem_we    = bus.core_we;
      bus.mem_be    = bus.core_be;
      bus.mem_addr  = bus.core_addr;
      bus.mem_wdata = bus.core_wdata;
    end else if (dma_gnt) begin
      bus.mem_en    = 1'b1;
      bus.mem_we    = bus.dma_we;
      bus.mem_be    = bus.dma_be;
      bus.mem_addr  = bus.dma_addr;
      bus.mem_wdata = bus.dma_wdata;
    end
  end

  assign bus.core_gnt = core_gnt;
  assign bus.dma_gnt  = dma_gnt;
  assign dma_denied   = bus.dma_req & ~dma_gnt;

  // Next-state: priority FSM, starvation and burst counters, response tracking
  always_comb begin
    state_d      = state_q;
    burst_d      = burst_q;
    wait_d       = 4'd0;
    resp_valid_d = bus.mem_en & ~bus.mem_we;
    resp_owner_d = dma_gnt;

    if (dma_denied) begin
      wait_d = (wait_q >= WAIT_MAX) ? WAIT_MAX : wait_q + 4'd1;
    end

    case (state_q)
      PRI_CORE: begin
        // Held at zero so the burst count starts fresh on entry to PRI_DMA
        burst_d = 4'd0;
        if (dma_denied && (wait_q == WAIT_LAST)) begin
          state_d = PRI_DMA;
        end
      end
      PRI_DMA: begin
        if (!bus.dma_req || (burst_q == BURST_LAST)) begin
          // DMA went away, or this cycle's grant completes the burst
          state_d = PRI_CORE;
          burst_d = 4'd0;
        end else begin
          burst_d = burst_q + 4'd1;
        end
      end
      default: begin
        state_d = PRI_CORE;
        burst_d = 4'd0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= PRI_CORE;
      wait_q       <= 4'd0;
      burst_q      <= 4'd0;
      resp_valid_q <= 1'b0;
      resp_owner_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      wait_q       <= wait_d;
      burst_q      <= burst_d;
      resp_valid_q <= resp_valid_d;
      resp_owner_q <= resp_owner_d;
    end
  end

  // Response steering: only the owner sees data, the other side reads zero
  assign bus.core_rvalid = resp_valid_q & ~resp_owner_q;
  assign bus.dma_rvalid  = resp_valid_q &  resp_owner_q;
  assign bus.core_rdata  = bus.core_rvalid ? bus.mem_rdata : 32'b0;
  assign bus.dma_rdata   = bus.dma_rvalid  ? bus.mem_rdata : 32'b0;

`ifdef DMEM_ARB_PERF_EN
  logic [31:0] perf_core_q, perf_dma_q, perf_conf_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      perf_core_q <= 32'd0;
      perf_dma_q  <= 32'd0;
      perf_conf_q <= 32'd0;
    end else begin
      perf_core_q <= perf_core_q + {31'd0, core_gnt};
      perf_dma_q  <= perf_dma_q  + {31'd0, dma_gnt};
      perf_conf_q <= perf_conf_q + {31'd0, bus.core_req & bus.dma_req};
    end
  end

  assign bus.perf_core_grants = perf_core_q;
  assign bus.perf_dma_grants  = perf_dma_q;
  assign bus.perf_conflicts   = perf_conf_q;
`endif

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// tb/tb_dmem_port_arbiter.sv - self-checking bench for dmem_port_arbiter (MAX_WAIT=4, DMA_BURST=2)
module tb_dmem_port_arbiter;

  typedef struct packed {
    logic        req;
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
  } req_t;

  typedef struct packed {
    logic        owner;
    logic [31:0] data;
  } resp_t;

  logic clk;
  logic reset;
  int   checks;
  int   passed;
  int   fails;

  logic [31:0] ref_mem [16];
  logic [31:0] mem_arr [16];
  resp_t       sb [$];

  dmem_port_arbiter_if ifc ();

  dmem_port_arbiter #(.MAX_WAIT(4), .DMA_BURST(2)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (ifc.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory: reads return data the cycle after the access
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 16; i++) mem_arr[i] <= 32'd0;
      mem_arr[0] <= 32'h11111111;
      mem_arr[1] <= 32'h22222222;
      mem_arr[4] <= 32'hDEADBEEF;
      ifc.mem_rdata <= 32'd0;
    end else if (ifc.mem_en) begin
      if (ifc.mem_we) begin
        for (int b = 0; b < 4; b++)
          if (ifc.mem_be[b]) mem_arr[ifc.mem_addr[5:2]][8*b +: 8] <= ifc.mem_wdata[8*b +: 8];
      end else begin
        ifc.mem_rdata <= mem_arr[ifc.mem_addr[5:2]];
      end
    end
  end

  task automatic ref_init();
    for (int i = 0; i < 16; i++) ref_mem[i] = 32'd0;
    ref_mem[0] = 32'h11111111;
    ref_mem[1] = 32'h22222222;
    ref_mem[4] = 32'hDEADBEEF;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic req_t idle();
    return '0;
  endfunction

  function automatic req_t rd(input logic [31:0] a);
    req_t r;
    r = '0;
    r.req = 1'b1;
    r.addr = a;
    return r;
  endfunction

  function automatic req_t wr(input logic [3:0] be, input logic [31:0] a, input logic [31:0] d);
    req_t r;
    r.req = 1'b1;
    r.we = 1'b1;
    r.be = be;
    r.addr = a;
    r.wdata = d;
    return r;
  endfunction

  task automatic drive(input req_t c, input req_t d);
    ifc.core_req = c.req; ifc.core_we = c.we; ifc.core_be = c.be;
    ifc.core_addr = c.addr; ifc.core_wdata = c.wdata;
    ifc.dma_req = d.req; ifc.dma_we = d.we; ifc.dma_be = d.be;
    ifc.dma_addr = d.addr; ifc.dma_wdata = d.wdata;
  endtask

  task automatic check_resp(input string tag);
    resp_t e;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk({tag, "_core_rvalid"}, 32'(ifc.core_rvalid), 32'(!e.owner));
      chk({tag, "_dma_rvalid"},  32'(ifc.dma_rvalid),  32'(e.owner));
      chk({tag, "_core_rdata"},  ifc.core_rdata, e.owner ? 32'd0 : e.data);
      chk({tag, "_dma_rdata"},   ifc.dma_rdata,  e.owner ? e.data : 32'd0);
    end else begin
      chk({tag, "_no_rvalid"}, {30'd0, ifc.core_rvalid, ifc.dma_rvalid}, 32'd0);
      chk({tag, "_rdata_zero"}, ifc.core_rdata | ifc.dma_rdata, 32'd0);
    end
  endtask

  // One cycle: drive, check at the falling edge, predict the response
  task automatic step(input req_t c, input req_t d, input logic exp_cg, input logic exp_dg,
                      input string tag);
    req_t w;
    resp_t e;
    drive(c, d);
    @(negedge clk);
    check_resp(tag);
    chk({tag, "_core_gnt"}, 32'(ifc.core_gnt), 32'(exp_cg));
    chk({tag, "_dma_gnt"},  32'(ifc.dma_gnt),  32'(exp_dg));
    chk({tag, "_mem_en"},   32'(ifc.mem_en),   32'(exp_cg | exp_dg));
    w = exp_cg ? c : (exp_dg ? d : idle());
    chk({tag, "_mem_we"},    32'(ifc.mem_we), 32'(w.we));
    chk({tag, "_mem_be"},    32'(ifc.mem_be), 32'(w.be));
    chk({tag, "_mem_addr"},  ifc.mem_addr,    w.addr);
    chk({tag, "_mem_wdata"}, ifc.mem_wdata,   w.wdata);
    if (exp_cg | exp_dg) begin
      if (w.we) begin
        for (int b = 0; b < 4; b++)
          if (w.be[b]) ref_mem[w.addr[5:2]][8*b +: 8] = w.wdata[8*b +: 8];
      end else begin
        e.owner = exp_dg;
        e.data  = ref_mem[w.addr[5:2]];
        sb.push_back(e);
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks = 0;
    passed = 0;
    fails  = 0;
    ref_init();
    reset = 1'b1;
    drive(idle(), idle());
    ifc.core_be = 4'hF;
    ifc.core_addr = 32'h40;
    ifc.dma_addr = 32'h44;
    ifc.dma_wdata = 32'hFFFFFFFF;

    // Reset state, with request fields non-zero but req low
    @(negedge clk);
    chk("rst_gnt", {30'd0, ifc.core_gnt, ifc.dma_gnt}, 32'd0);
    chk("rst_rvalid", {30'd0, ifc.core_rvalid, ifc.dma_rvalid}, 32'd0);
    chk("rst_mem", {31'd0, ifc.mem_en} | ifc.mem_addr | ifc.mem_wdata | 32'(ifc.mem_be), 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;

    // Core-only read, then its response
    step(rd(32'h10), idle(), 1'b1, 1'b0, "t1_read");
    step(idle(), idle(), 1'b0, 1'b0, "t1_resp");

    // DMA-only write, no response afterwards
    step(idle(), wr(4'b0011, 32'h20, 32'h1234ABCD), 1'b0, 1'b1, "t2_write");
    step(idle(), idle(), 1'b0, 1'b0, "t2_after");

    // Starvation: core 4 cycles, DMA 2 cycles, repeating
    for (int i = 0; i < 12; i++)
      step(rd(32'h10), wr(4'hF, 32'h24, 32'(i)), (i % 6) < 4, (i % 6) >= 4, "t3_starve");
    step(idle(), idle(), 1'b0, 1'b0, "t3_drain");

    // Interleaved reads, responses must not cross
    step(rd(32'h0), idle(), 1'b1, 1'b0, "t4_core_rd");
    step(idle(), rd(32'h4), 1'b0, 1'b1, "t4_dma_rd");
    step(idle(), idle(), 1'b0, 1'b0, "t4_drain");

    // Early exit from PRI_DMA when DMA drops its request
    for (int i = 0; i < 4; i++)
      step(rd(32'h10), rd(32'h4), 1'b1, 1'b0, "t5_wait");
    step(rd(32'h10), rd(32'h4), 1'b0, 1'b1, "t5_forced");
    step(rd(32'h10), idle(), 1'b1, 1'b0, "t5_drop");
    step(rd(32'h10), rd(32'h4), 1'b1, 1'b0, "t5_pri_core");
    step(idle(), idle(), 1'b0, 1'b0, "t5_drain");

    // Reset in the cycle after a granted read drops the response
    step(rd(32'h10), idle(), 1'b1, 1'b0, "t6_read");
    reset = 1'b1;
    drive(idle(), idle());
    @(negedge clk);
    chk("t6_no_core_rvalid", 32'(ifc.core_rvalid), 32'd0);
    chk("t6_no_dma_rvalid", 32'(ifc.dma_rvalid), 32'd0);
    chk("t6_rdata_zero", ifc.core_rdata | ifc.dma_rdata, 32'd0);
`ifdef DMEM_ARB_PERF_EN
    chk("t6_perf_core", ifc.perf_core_grants, 32'd0);
    chk("t6_perf_dma", ifc.perf_dma_grants, 32'd0);
    chk("t6_perf_conf", ifc.perf_conflicts, 32'd0);
`endif
    sb.delete();
    ref_init();
    @(posedge clk);
    #1;
    reset = 1'b0;
    step(idle(), idle(), 1'b0, 1'b0, "t6_after");
    // Counters cleared: a full 4-core / 2-DMA period from scratch
    for (int i = 0; i < 6; i++)
      step(wr(4'hF, 32'h30, 32'(i)), wr(4'hF, 32'h34, 32'(i)), i < 4, i >= 4, "t6_starve");
`ifdef DMEM_ARB_PERF_EN
    @(negedge clk);
    chk("perf_core", ifc.perf_core_grants, 32'd4);
    chk("perf_dma", ifc.perf_dma_grants, 32'd2);
    chk("perf_conf", ifc.perf_conflicts, 32'd6);
`endif
    step(idle(), idle(), 1'b0, 1'b0, "end_drain");

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: observed no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/dmem_port_arbiter.md
Name: dmem_port_arbiter

Overview:
Shares the single data-memory port between two requesters: the core MEM stage (requester 0) and a DMA/debug master (requester 1).
- Grants one requester per cycle and drives the memory port combinationally from the winner.
- Routes the 1-cycle-latency read response back to the requester that issued the read.
- The core has default priority. A starvation counter forces a bounded DMA burst so DMA always makes progress.

Parameters:
- MAX_WAIT, 4, consecutive cycles of DMA request without a grant that trigger forced DMA priority (1..15).
- DMA_BURST, 2, maximum consecutive DMA grants while in forced priority (1..15).

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- core_req  in  1  core access request
- core_we  in  1  core write (1) / read (0)
- core_be  in  4  core byte enables (writes)
- core_addr  in  32  core byte address
- core_wdata  in  32  core write data
- core_gnt  out  1  core access accepted this cycle; low = core must stall
- core_rvalid  out  1  core read data valid
- core_rdata  out  32  core read data
- dma_req, dma_we, dma_be, dma_addr, dma_wdata  in  1/1/4/32/32  DMA request fields, same meaning as core_*
- dma_gnt  out  1  DMA access accepted this cycle
- dma_rvalid  out  1  DMA read data valid
- dma_rdata  out  32  DMA read data
- mem_en  out  1  memory access this cycle
- mem_we  out  1  memory write enable
- mem_be  out  4  memory byte enables
- mem_addr  out  32  memory address
- mem_wdata  out  32  memory write data
- mem_rdata  in  32  memory read data, valid the cycle after a read access

Behaviour:
- FSM states: PRI_CORE (reset state) and PRI_DMA.
- Grant, combinational:
  - PRI_CORE: core_gnt = core_req; dma_gnt = dma_req & ~core_req.
  - PRI_DMA: dma_gnt = dma_req; core_gnt = core_req & ~dma_req.
  - At most one grant per cycle.
- Memory port:
  - mem_en = core_gnt | dma_gnt; mem_we = granted requester's we.
  - mem_be/addr/wdata are muxed from the winner.
  - When idle, all mem_* outputs are 0.
- Wait counter (4 bits):
  - Increments when dma_req & ~dma_gnt.
  - Saturates at MAX_WAIT.
  - Clears when dma_gnt or ~dma_req.
- Transitions:
  - PRI_CORE -> PRI_DMA at the clock edge where the wait counter == MAX_WAIT-1 and DMA is still denied.
  - PRI_DMA -> PRI_CORE when either:
    - the burst counter reaches DMA_BURST grants, or
    - dma_req is low in any PRI_DMA cycle.
  - The burst counter clears on entering PRI_DMA.
- Response:
  - A granted read (gnt & ~we) sets a registered resp_valid with resp_owner = winner.
  - The next cycle, the owner's rvalid = 1 and the owner's rdata = mem_rdata.
  - The non-owner's rvalid = 0 and its rdata = 0.
  - Writes produce no response.
- Throughput: back-to-back reads are allowed; a response and a new grant may occur in the same cycle.
- Reset values:
  - rvalid outputs 0, rdata outputs 0, FSM PRI_CORE, all counters 0.
  - gnt and mem_* outputs are 0 when req is low.
  - Reset mid-read drops the pending response; no rvalid follows deassertion.
- Simultaneous requests:
  - Priority follows the state.
  - The loser holds its request stable until granted; the arbiter does not latch loser fields.

Optional Feature:
- Macro: DMEM_ARB_PERF_EN.
- When defined:
  - Adds outputs perf_core_grants[31:0], perf_dma_grants[31:0] and perf_conflicts[31:0].
  - perf_conflicts counts cycles with both requests active.
  - Counters are wrapping, reset to 0, and increment at the clock edge following the event.
- When undefined: ports and logic are absent; behaviour is otherwise identical.

Test Plan:
1. Core-only read: core_req=1, we=0, addr=0x10, memory word 0xDEADBEEF -> core_gnt=1 same cycle; core_rvalid=1, core_rdata=0xDEADBEEF the next cycle; dma_rvalid=0.
2. DMA-only write: dma_req=1, we=1, be=4'b0011, addr=0x20, wdata=0x1234ABCD -> dma_gnt=1, mem_we=1, mem_be=0011; no rvalid the next cycle.
3. Starvation, MAX_WAIT=4, DMA_BURST=2: core_req and dma_req held high ->
   - core granted cycles 0-3;
   - DMA granted cycles 4-5;
   - core regains the grant at cycle 6;
   - pattern repeats with period 6.
4. Interleaved reads: core reads 0x0 (0x11111111) at cycle n, DMA reads 0x4 (0x22222222) at cycle n+1 -> core_rvalid with 0x11111111 at n+1, dma_rvalid with 0x22222222 at n+2, never crossed.
5. Early exit: enter PRI_DMA, then drop dma_req after 1 grant -> the FSM returns to PRI_CORE next cycle; the core is granted immediately.
6. Reset mid-read: assert reset in the cycle after a granted read -> no rvalid; FSM PRI_CORE; counters 0. With DMEM_ARB_PERF_EN, perf counters read 0.
